// File: rtl/iic_slave_regfile_if.sv
// Bus-side and host-side signal bundle for iic_slave_regfile.
//   slave  modport : used by the register-file slave (DUT side)
//   master modport : used by whatever drives the I2C pins and host port
// Signals:
//   scl, sda_in          raw I2C pins (asynchronous to clk)
//   sda_oe               1 = pull SDA low, 0 = release
//   host_we/addr/wdata   host register write port
//   host_rdata           combinational read of register host_addr
//   bus_wr, bus_wr_addr  one-clk pulse and index when the bus writes a register
//   busy                 addressed transfer in progress
interface iic_slave_regfile_if #(
   parameter int AW = 2
);
   logic          scl;
   logic          sda_in;
   logic          sda_oe;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [7:0]    host_wdata;
   logic [7:0]    host_rdata;
   logic          bus_wr;
   logic [AW-1:0] bus_wr_addr;
   logic          busy;

   modport slave (
      input  scl, sda_in, host_we, host_addr, host_wdata,
      output sda_oe, host_rdata, bus_wr, bus_wr_addr, busy
   );

   modport master (
      output scl, sda_in, host_we, host_addr, host_wdata,
      input  sda_oe, host_rdata, bus_wr, bus_wr_addr, busy
   );
endinterface

// File: rtl/iic_slave_regfile.sv
// I2C slave exposing NUM_REGS 8-bit registers, shared with a host port.
// Bus protocol: [START] addr+W, pointer, data... or [START] addr+R, data...
// The pointer auto-increments (wrapping) after every written byte and every
// ACKed read byte, and survives repeated START and STOP.
// Ports:
//   clk    system clock (>= 8x SCL)
//   rst_n  asynchronous active-low reset
//   bus    iic_slave_regfile_if.slave (pins, host port, status)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | not addressed, waiting for START
// ADDR      | shifting in the 7-bit address + R/W bit
// ADDR_ACK  | driving ACK for a matched address
// PTR       | shifting in the register pointer byte
// PTR_ACK   | driving ACK for a valid pointer
// WDATA     | shifting in a write data byte
// WDATA_ACK | driving ACK for a written byte
// RDATA     | shifting out register[pointer], MSB first
// RACK      | sampling the master's ACK/NACK after a read byte
module iic_slave_regfile #(
   parameter logic [6:0] DEV_ADDR = 7'h01,
   parameter int         NUM_REGS = 4,
   parameter int         AW       = 2
) (
   input logic                clk,
   input logic                rst_n,
   iic_slave_regfile_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
   } state_t;

   state_t        r_state, w_state_nxt;

   logic          r_scl_s1, r_scl_s2, r_scl_d;
   logic          r_sda_s1, r_sda_s2, r_sda_d;
   logic          w_scl_rise, w_scl_fall, w_start, w_stop;

   logic [3:0]    r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0]    r_shift, w_shift_nxt;
   logic [AW-1:0] r_ptr, w_ptr_nxt, w_ptr_inc;
   logic          r_sda_oe, w_sda_oe_nxt;
   logic          r_busy, w_busy_nxt;
   logic          r_bus_wr;
   logic [AW-1:0] r_bus_wr_addr;
   logic          w_bus_we;
   logic          w_ptr_ok;

   logic [7:0]    r_regs [NUM_REGS];
   logic [7:0]    w_ptr_data, w_host_rdata;

   // Synchronisers; the third flop of each chain is the "previous" value
   // used for edge detection, so every decision uses settled samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_s1 <= 1'b1;
         r_scl_s2 <= 1'b1;
         r_scl_d  <= 1'b1;
         r_sda_s1 <= 1'b1;
         r_sda_s2 <= 1'b1;
         r_sda_d  <= 1'b1;
      end else begin
         r_scl_s1 <= bus.scl;
         r_scl_s2 <= r_scl_s1;
         r_scl_d  <= r_scl_s2;
         r_sda_s1 <= bus.sda_in;
         r_sda_s2 <= r_sda_s1;
         r_sda_d  <= r_sda_s2;
      end
   end

   assign w_scl_rise = r_scl_s2 & ~r_scl_d;
   assign w_scl_fall = ~r_scl_s2 & r_scl_d;
   assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
   assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

   // Register read muxes built as loops so a non-power-of-two NUM_REGS
   // never indexes past the array.
   always_comb begin
      w_ptr_data   = 8'h00;
      w_host_rdata = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (r_ptr == AW'(i))         w_ptr_data   = r_regs[i];
         if (bus.host_addr == AW'(i)) w_host_rdata = r_regs[i];
      end
   end

   assign w_ptr_inc = (r_ptr == AW'(NUM_REGS - 1)) ? '0 : r_ptr + AW'(1);
   assign w_ptr_ok  = (32'(r_shift) < NUM_REGS);

   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_ptr_nxt     = r_ptr;
      w_sda_oe_nxt  = r_sda_oe;
      w_bus_we      = 1'b0;

      if (w_start) begin
         w_state_nxt   = ADDR;
         w_bit_cnt_nxt = 4'd0;
         w_sda_oe_nxt  = 1'b0;
      end else if (w_stop) begin
         w_state_nxt  = IDLE;
         w_sda_oe_nxt = 1'b0;
      end else begin
         if ((r_state == ADDR || r_state == PTR || r_state == WDATA) &&
             w_scl_rise && (r_bit_cnt != 4'd8)) begin
            w_shift_nxt   = {r_shift[6:0], r_sda_s2};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
         end

         case (r_state)
            IDLE: begin
            end

            ADDR: begin
               if (w_scl_fall && r_bit_cnt == 4'd8) begin
                  if (r_shift[7:1] == DEV_ADDR) begin
                     w_state_nxt  = ADDR_ACK;
                     w_sda_oe_nxt = 1'b1;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end
            end

            // R/W bit is still held in r_shift[0] throughout the ACK slot.
            ADDR_ACK: begin
               if (w_scl_fall) begin
                  w_bit_cnt_nxt = 4'd0;
                  if (r_shift[0]) begin
                     w_state_nxt  = RDATA;
                     w_shift_nxt  = w_ptr_data;
                     w_sda_oe_nxt = ~w_ptr_data[7];
                  end else begin
                     w_state_nxt  = PTR;
                     w_sda_oe_nxt = 1'b0;
                  end
               end
            end

            PTR: begin
               if (w_scl_fall && r_bit_cnt == 4'd8) begin
                  if (w_ptr_ok) begin
                     w_ptr_nxt    = r_shift[AW-1:0];
                     w_state_nxt  = PTR_ACK;
                     w_sda_oe_nxt = 1'b1;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end
            end

            PTR_ACK, WDATA_ACK: begin
               if (w_scl_fall) begin
                  w_state_nxt   = WDATA;
                  w_bit_cnt_nxt = 4'd0;
                  w_sda_oe_nxt  = 1'b0;
               end
            end

            WDATA: begin
               if (w_scl_fall && r_bit_cnt == 4'd8) begin
                  w_bus_we     = 1'b1;
                  w_ptr_nxt    = w_ptr_inc;
                  w_state_nxt  = WDATA_ACK;
                  w_sda_oe_nxt = 1'b1;
               end
            end

            // Bit 7 is already on the line at entry; each later falling edge
            // presents the next bit until all eight have been clocked.
            RDATA: begin
               if (w_scl_rise) begin
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               end else if (w_scl_fall && r_bit_cnt != 4'd0) begin
                  if (r_bit_cnt == 4'd8) begin
                     w_state_nxt   = RACK;
                     w_bit_cnt_nxt = 4'd0;
                     w_sda_oe_nxt  = 1'b0;
                  end else begin
                     w_shift_nxt  = {r_shift[6:0], 1'b0};
                     w_sda_oe_nxt = ~r_shift[6];
                  end
               end
            end

            // bit_cnt=1 marks "ACK seen, pointer already advanced".
            RACK: begin
               if (w_scl_rise) begin
                  if (!r_sda_s2) begin
                     w_ptr_nxt     = w_ptr_inc;
                     w_bit_cnt_nxt = 4'd1;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else if (w_scl_fall && r_bit_cnt == 4'd1) begin
                  w_state_nxt   = RDATA;
                  w_bit_cnt_nxt = 4'd0;
                  w_shift_nxt   = w_ptr_data;
                  w_sda_oe_nxt  = ~w_ptr_data[7];
               end
            end

            default: begin
               w_state_nxt  = IDLE;
               w_sda_oe_nxt = 1'b0;
            end
         endcase
      end

      // busy rises on an address match and holds across repeated START.
      if (w_state_nxt == IDLE)
         w_busy_nxt = 1'b0;
      else if (w_state_nxt == ADDR_ACK)
         w_busy_nxt = 1'b1;
      else
         w_busy_nxt = r_busy;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_bit_cnt     <= 4'd0;
         r_shift       <= 8'h00;
         r_ptr         <= '0;
         r_sda_oe      <= 1'b0;
         r_busy        <= 1'b0;
         r_bus_wr      <= 1'b0;
         r_bus_wr_addr <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_ptr     <= w_ptr_nxt;
         r_sda_oe  <= w_sda_oe_nxt;
         r_busy    <= w_busy_nxt;
         r_bus_wr  <= w_bus_we;
         if (w_bus_we)
            r_bus_wr_addr <= r_ptr;
      end
   end

   // A bus write wins over a host write to the same register; host writes
   // to other registers in the same clk still land.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_regs[i] <= 8'h00;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_bus_we && r_ptr == AW'(i))
               r_regs[i] <= r_shift;
            else if (bus.host_we && bus.host_addr == AW'(i))
               r_regs[i] <= bus.host_wdata;
         end
      end
   end

   assign bus.sda_oe      = r_sda_oe;
   assign bus.busy        = r_busy;
   assign bus.bus_wr      = r_bus_wr;
   assign bus.bus_wr_addr = r_bus_wr_addr;
   assign bus.host_rdata  = w_host_rdata;

endmodule

// File: tb/tb_iic_slave_regfile.sv
`timescale 1ns/1ps
module tb_iic_slave_regfile;
   localparam int Q = 80;   // quarter SCL period: 8 clk

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_line;
   int         vec_cnt = 0;
   int         err_cnt = 0;
   logic [8:0] exp_frame_q[$];
   logic [1:0] exp_wr_q[$];
   logic       saw, done, hit;

   iic_slave_regfile_if #(.AW(2)) bus();

   iic_slave_regfile #(
      .DEV_ADDR(7'h01),
      .NUM_REGS(4),
      .AW(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   assign sda_line   = m_sda & ~bus.sda_oe;
   assign bus.scl    = m_scl;
   assign bus.sda_in = sda_line;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_reg(input int idx, input logic [7:0] exp);
      bus.host_addr = 2'(idx);
      #1;
      check($sformatf("reg%0d", idx), 32'(bus.host_rdata), 32'(exp));
   endtask

   task automatic expf(input logic [7:0] b, input logic a);
      exp_frame_q.push_back({b, a});
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; #Q;
      m_scl = 1'b1; #Q;
      m_sda = 1'b0; #Q;
      m_scl = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; #Q;
      m_scl = 1'b1; #Q;
      m_sda = 1'b1; #Q;
   endtask

   task automatic send_bit(input logic b);
      m_sda = b; #Q;
      m_scl = 1'b1; #(2*Q);
      m_scl = 1'b0; #Q;
   endtask

   task automatic wr_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      send_bit(1'b1);
   endtask

   task automatic rd_byte(input logic ack);
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      send_bit(ack);
   endtask

   task automatic host_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.host_addr = a; bus.host_wdata = d; bus.host_we = 1'b1;
      @(negedge clk);
      bus.host_we = 1'b0;
   endtask

   // Bus monitor: decodes 9-bit frames from the wired-AND line and
   // checks each against the next expected {byte, ack}.
   initial begin : frame_mon
      logic       p_scl, p_sda, in_frame;
      int         nb;
      logic [8:0] sh;
      p_scl = 1'b1; p_sda = 1'b1; in_frame = 1'b0; nb = 0; sh = '0;
      forever begin
         @(m_scl or sda_line);
         if (m_scl && !p_scl) begin
            if (in_frame) begin
               sh = {sh[7:0], sda_line};
               nb++;
               if (nb == 9) begin
                  if (exp_frame_q.size() == 0) begin
                     vec_cnt++; err_cnt++;
                     $display("FAIL frame: got 0x%0h expected none", sh);
                  end else begin
                     check("frame", 32'(sh), 32'(exp_frame_q.pop_front()));
                  end
                  nb = 0;
               end
            end
         end else if (m_scl && p_scl && (sda_line !== p_sda)) begin
            in_frame = !sda_line;
            nb = 0;
         end
         p_scl = m_scl;
         p_sda = sda_line;
      end
   end

   // Write-strobe monitor.
   always @(negedge clk) begin
      if (rst_n && bus.bus_wr === 1'b1) begin
         if (exp_wr_q.size() == 0) begin
            vec_cnt++; err_cnt++;
            $display("FAIL bus_wr: got pulse addr %0d expected none", bus.bus_wr_addr);
         end else begin
            check("bus_wr_addr", 32'(bus.bus_wr_addr), 32'(exp_wr_q.pop_front()));
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_sda_oe", 32'(bus.sda_oe), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_bus_wr", 32'(bus.bus_wr), 0);
      check("rst_bus_wr_addr", 32'(bus.bus_wr_addr), 0);
      for (int i = 0; i < 4; i++) chk_reg(i, 8'h00);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // write pointer 1, data A5, 3C
      expf(8'h02, 0); expf(8'h01, 0); expf(8'hA5, 0); expf(8'h3C, 0);
      exp_wr_q.push_back(2'd1); exp_wr_q.push_back(2'd2);
      i2c_start(); wr_byte(8'h02); wr_byte(8'h01);
      check("busy_mid", 32'(bus.busy), 1);
      wr_byte(8'hA5); wr_byte(8'h3C); i2c_stop();
      check("stop_busy", 32'(bus.busy), 0);
      check("stop_sda_oe", 32'(bus.sda_oe), 0);
      chk_reg(1, 8'hA5); chk_reg(2, 8'h3C);

      // read with wrap and repeated START; host write during byte in flight
      host_write(2'd3, 8'h7E); host_write(2'd0, 8'h81);
      expf(8'h02, 0); expf(8'h03, 0); expf(8'h03, 0); expf(8'h7E, 0); expf(8'h81, 1);
      i2c_start(); wr_byte(8'h02); wr_byte(8'h03);
      i2c_start(); wr_byte(8'h03);
      fork
         rd_byte(1'b0);
         begin #(6*Q); host_write(2'd3, 8'h00); end
      join
      rd_byte(1'b1); i2c_stop();
      check("rd_busy", 32'(bus.busy), 0);
      chk_reg(3, 8'h00);

      // foreign address: no response at all
      expf(8'h44, 1); expf(8'h12, 1);
      saw = 1'b0; done = 1'b0;
      fork
         begin i2c_start(); wr_byte(8'h44); wr_byte(8'h12); i2c_stop(); done = 1'b1; end
         begin
            while (!done) begin
               @(negedge clk);
               if (bus.sda_oe || bus.busy) saw = 1'b1;
            end
         end
      join
      check("foreign_oe_busy", 32'(saw), 0);
      chk_reg(0, 8'h81); chk_reg(1, 8'hA5); chk_reg(2, 8'h3C); chk_reg(3, 8'h00);

      // out-of-range pointer: NACK, following data ignored
      expf(8'h02, 0); expf(8'h05, 1); expf(8'hAB, 1);
      i2c_start(); wr_byte(8'h02); wr_byte(8'h05); wr_byte(8'hAB); i2c_stop();
      check("badptr_busy", 32'(bus.busy), 0);
      for (int i = 0; i < 4; i++) chk_reg(i, (i == 0) ? 8'h81 : (i == 1) ? 8'hA5 : (i == 2) ? 8'h3C : 8'h00);

      // host/bus collision on reg1: bus write wins
      expf(8'h02, 0); expf(8'h01, 0); expf(8'h99, 0);
      exp_wr_q.push_back(2'd1);
      i2c_start(); wr_byte(8'h02); wr_byte(8'h01);
      @(negedge clk);
      hit = 1'b0;
      fork
         wr_byte(8'h99);
         begin
            bus.host_addr = 2'd1; bus.host_wdata = 8'h11; bus.host_we = 1'b1;
            for (int i = 0; i < 600 && !hit; i++) begin
               @(negedge clk);
               if (bus.bus_wr) hit = 1'b1;
            end
            bus.host_we = 1'b0;
            check("collide_seen", 32'(hit), 1);
         end
      join
      i2c_stop();
      chk_reg(1, 8'h99);

      // reset during third bit of a read of reg0 (0x81: bit5=0 -> pulled low)
      expf(8'h02, 0); expf(8'h00, 0); expf(8'h03, 0);
      i2c_start(); wr_byte(8'h02); wr_byte(8'h00);
      i2c_start(); wr_byte(8'h03);
      send_bit(1'b1); send_bit(1'b1);
      m_sda = 1'b1; #Q;
      check("rd_bit3_oe", 32'(bus.sda_oe), 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_async_oe", 32'(bus.sda_oe), 0);
      check("rst_async_busy", 32'(bus.busy), 0);
      for (int i = 0; i < 4; i++) chk_reg(i, 8'h00);
      #20;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      expf(8'h02, 0); expf(8'h02, 0); expf(8'h5A, 0);
      exp_wr_q.push_back(2'd2);
      i2c_start(); wr_byte(8'h02); wr_byte(8'h02); wr_byte(8'h5A); i2c_stop();
      chk_reg(2, 8'h5A); chk_reg(0, 8'h00);

      repeat (10) @(negedge clk);
      check("frames_left", 32'(exp_frame_q.size()), 0);
      check("wr_left", 32'(exp_wr_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
